// File: rtl/wb_pkg.sv
// -----------------------------------------------------------------------------
// wb_pkg
// Shared definitions for the Wishbone line master.
//   wb_state_e : line-master FSM encoding (IDLE / BUS / DONE)
//   WB_DW      : Wishbone data width (32)
//   WB_SELW    : Wishbone byte-select width (4)
// -----------------------------------------------------------------------------
package wb_pkg;

  localparam int WB_DW   = 32;
  localparam int WB_SELW = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_DONE = 2'd2
  } wb_state_e;

endpackage

// File: rtl/wb_line_master.sv
// -----------------------------------------------------------------------------
// wb_line_master
// Wishbone classic master that turns one cache-line request into BEATS
// single-word cycles. Beats run in wrap-around order: critical word first,
// then the remaining words of the aligned line, with the upper address bits
// held constant.
//
// Optional feature (compile-time macro WB_TIMEOUT_EN):
//   defined   - per-beat ack timeout of TIMEOUT cycles; on expiry the line is
//               aborted and done is reported with err = 1.
//   undefined - the master waits for ack_i indefinitely; err is always 0.
//
// Ports
//   clk_i, rst_i            clock, synchronous active-high reset
//   req_valid/req_ready     line request handshake
//   req_addr/req_we/req_sel critical-word address, direction, byte lanes
//   wr_data/wr_next         write data for current beat / beat-consumed pulse
//   rd_valid/rd_data/rd_last registered read beat, last-beat qualifier
//   done/err                line-finished pulse / aborted-by-timeout flag
//   cyc_o stb_o we_o adr_o sel_o dat_o ack_i dat_i   Wishbone master side
// -----------------------------------------------------------------------------
module wb_line_master
  import wb_pkg::*;
#(
  parameter int AW      = 10,
  parameter int BEATS   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [AW-1:0]      req_addr,
  input  logic               req_we,
  input  logic [WB_SELW-1:0] req_sel,
  input  logic [WB_DW-1:0]   wr_data,
  output logic               wr_next,
  output logic               rd_valid,
  output logic [WB_DW-1:0]   rd_data,
  output logic               rd_last,
  output logic               done,
  output logic               err,
  output logic               cyc_o,
  output logic               stb_o,
  output logic               we_o,
  output logic [AW-1:0]      adr_o,
  output logic [WB_SELW-1:0] sel_o,
  output logic [WB_DW-1:0]   dat_o,
  input  logic               ack_i,
  input  logic [WB_DW-1:0]   dat_i
);

  localparam int BW = $clog2(BEATS);

  wb_state_e            state_reg, state_next;
  logic [AW-1:0]        addr_reg;
  logic                 we_reg;
  logic [WB_SELW-1:0]   sel_reg;
  logic [BW-1:0]        cnt_reg;
  logic                 beat_first_reg;
  logic                 aborted_reg;
  logic                 rd_valid_reg, rd_last_reg;
  logic [WB_DW-1:0]     rd_data_reg;
  logic                 done_reg, err_reg;

  logic                 in_bus;
  logic                 accept;
  logic                 beat_ack;
  logic                 last_beat;
  logic                 timeout_hit;
  logic [BW-1:0]        low_addr;

  assign in_bus    = (state_reg == ST_BUS);
  assign accept    = req_valid & req_ready;
  assign last_beat = (cnt_reg == BW'(BEATS - 1));
  // Low address bits wrap inside the aligned line.
  assign low_addr  = addr_reg[BW-1:0] + cnt_reg;

  // The first BUS cycle of each beat is skipped: an ack there still belongs
  // to the previous address. A reset cycle never completes a beat, so no
  // wr_next escapes while the line is being torn down.
  assign beat_ack  = in_bus & ~beat_first_reg & ack_i & ~rst_i;

`ifdef WB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo_reg;

  assign timeout_hit = in_bus & ~beat_ack & ~rst_i & (tmo_reg == TW'(TIMEOUT - 1));

  // Counts BUS cycles since the current beat started.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tmo_reg <= '0;
    end else if (accept || beat_ack) begin
      tmo_reg <= '0;
    end else if (in_bus) begin
      tmo_reg <= tmo_reg + 1'b1;
    end
  end
`else
  // TIMEOUT has no effect in this build; the expression is constant 0.
  assign timeout_hit = 1'b0 && (TIMEOUT > 0);
`endif

  // Next-state / handshake logic.
  always_comb begin
    state_next = state_reg;
    req_ready  = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        // Hold off during the done pulse so a back-to-back request is only
        // taken once the previous line has been reported.
        req_ready = ~done_reg;
        if (req_valid && !done_reg) state_next = ST_BUS;
      end
      ST_BUS: begin
        if (timeout_hit || (beat_ack && last_beat)) state_next = ST_DONE;
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg      <= ST_IDLE;
      addr_reg       <= '0;
      we_reg         <= 1'b0;
      sel_reg        <= '0;
      cnt_reg        <= '0;
      beat_first_reg <= 1'b0;
      aborted_reg    <= 1'b0;
      rd_valid_reg   <= 1'b0;
      rd_last_reg    <= 1'b0;
      rd_data_reg    <= '0;
      done_reg       <= 1'b0;
      err_reg        <= 1'b0;
    end else begin
      state_reg    <= state_next;
      rd_valid_reg <= beat_ack & ~we_reg;
      rd_last_reg  <= beat_ack & ~we_reg & last_beat;
      if (beat_ack && !we_reg) rd_data_reg <= dat_i;

      // done/err are the registered view of the DONE state, so done lands
      // one cycle after the final read beat is presented.
      done_reg <= (state_reg == ST_DONE);
      err_reg  <= (state_reg == ST_DONE) & aborted_reg;

      if (accept) begin
        addr_reg       <= req_addr;
        we_reg         <= req_we;
        sel_reg        <= req_sel;
        cnt_reg        <= '0;
        beat_first_reg <= 1'b1;
        aborted_reg    <= 1'b0;
      end else if (beat_ack) begin
        cnt_reg        <= cnt_reg + 1'b1;
        beat_first_reg <= 1'b1;
      end else begin
        beat_first_reg <= 1'b0;
      end

      if (timeout_hit) aborted_reg <= 1'b1;
    end
  end

  assign cyc_o    = in_bus;
  assign stb_o    = in_bus;
  assign we_o     = in_bus & we_reg;
  assign adr_o    = {addr_reg[AW-1:BW], low_addr};
  assign sel_o    = sel_reg;
  assign dat_o    = wr_data;
  assign wr_next  = beat_ack & we_reg;
  assign rd_valid = rd_valid_reg;
  assign rd_data  = rd_data_reg;
  assign rd_last  = rd_last_reg;
  assign done     = done_reg;
  assign err      = err_reg;

endmodule

// File: tb/tb_wb_line_master.sv
// -----------------------------------------------------------------------------
// tb_wb_line_master
// Self-checking bench for wb_line_master. A wb_mem-style slave (1024 words,
// preloaded mem[i] = i, one registered ack per access) sits on the bus, and a
// plain array reference memory predicts every read beat in wrap order.
// -----------------------------------------------------------------------------
module tb_wb_line_master;
  import wb_pkg::*;

  localparam int AW    = 10;
  localparam int BEATS = 4;
  localparam int MSIZE = 1024;

  logic               clk_i = 1'b0;
  logic               rst_i;
  logic               req_valid;
  logic               req_ready;
  logic [AW-1:0]      req_addr;
  logic               req_we;
  logic [WB_SELW-1:0] req_sel;
  logic [WB_DW-1:0]   wr_data;
  logic               wr_next;
  logic               rd_valid;
  logic [WB_DW-1:0]   rd_data;
  logic               rd_last;
  logic               done;
  logic               err;
  logic               cyc_o, stb_o, we_o;
  logic [AW-1:0]      adr_o;
  logic [WB_SELW-1:0] sel_o;
  logic [WB_DW-1:0]   dat_o;
  logic               ack_i;
  logic [WB_DW-1:0]   dat_i;

  wb_line_master #(.AW(AW), .BEATS(BEATS), .TIMEOUT(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_we(req_we), .req_sel(req_sel),
    .wr_data(wr_data), .wr_next(wr_next),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last),
    .done(done), .err(err),
    .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .adr_o(adr_o),
    .sel_o(sel_o), .dat_o(dat_o), .ack_i(ack_i), .dat_i(dat_i)
  );

  always #5 clk_i = ~clk_i;

  // ---------------- wb_mem-style slave ----------------
  logic [31:0] mem [MSIZE];
  logic        mem_ack;
  logic [31:0] mem_dat;
  logic        mem_init;
  logic        force_nak;

  always @(posedge clk_i) begin
    if (mem_init) begin
      for (int i = 0; i < MSIZE; i++) mem[i] <= 32'(i);
    end
    if (rst_i) begin
      mem_ack <= 1'b0;
    end else if (cyc_o && stb_o && !mem_ack && !force_nak) begin
      mem_ack <= 1'b1;
      if (we_o) begin
        for (int b = 0; b < 4; b++)
          if (sel_o[b]) mem[adr_o][8*b +: 8] <= dat_o[8*b +: 8];
      end
    end else begin
      mem_ack <= 1'b0;
    end
    mem_dat <= mem[adr_o];
  end

  assign ack_i = mem_ack;
  assign dat_i = mem_dat;

  // ---------------- reference model & bookkeeping ----------------
  logic [31:0] ref_mem [MSIZE];
  int tests  = 0;
  int failed = 0;

  logic [31:0] rd_q[$];
  int  last_pos, wr_cnt, cyc_n, done_after_last, start_to_done;
  bit  got_done, got_err, cyc_at_done, early;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h, required %0h", tag, obs, exp);
    end
  endtask

  // Word address of beat k for a line starting at a (wrap inside aligned line).
  function automatic int beat_addr(input int a, input int k);
    return (a / BEATS) * BEATS + ((a % BEATS) + k) % BEATS;
  endfunction

  // Drive one line request and record everything the DUT does until done.
  task automatic run_line(input logic [AW-1:0] a, input logic w, input logic [3:0] s,
                          input logic [31:0] d0, input logic [31:0] d1,
                          input logic [31:0] d2, input logic [31:0] d3,
                          input bit hold_valid);
    logic [31:0] wd [4];
    int  widx, last_idx, first_cyc;
    bit  accepted;
    wd = '{d0, d1, d2, d3};
    rd_q.delete();
    last_pos = 0; wr_cnt = 0; cyc_n = 0; got_done = 0; got_err = 0;
    cyc_at_done = 0; early = 0; widx = 0; last_idx = -100; first_cyc = -1;
    done_after_last = -1; start_to_done = -1; accepted = 0;
    req_valid = 1'b1; req_addr = a; req_we = w; req_sel = s; wr_data = d0;
    for (int t = 0; t < 400 && !got_done; t++) begin
      @(negedge clk_i);
      if (accepted && !hold_valid) req_valid = 1'b0;
      if (cyc_o) begin
        cyc_n++;
        if (first_cyc < 0) first_cyc = t;
      end
      if (rd_valid) begin
        rd_q.push_back(rd_data);
        if (rd_last) begin last_pos = rd_q.size(); last_idx = t; end
      end
      if (wr_next) begin
        wr_cnt++;
        widx++;
        if (widx < 4) wr_data = wd[widx];
      end
      if (done) begin
        got_done = 1; got_err = err; cyc_at_done = cyc_o;
        done_after_last = t - last_idx;
        start_to_done = t - first_cyc;
      end else if (req_ready && req_valid) begin
        if (accepted) early = 1;
        accepted = 1;
      end
    end
    if (!hold_valid) req_valid = 1'b0;
    $display("[TB] line addr=%03h we=%0b sel=%0h: done=%0b err=%0b rd=%0d wr=%0d cyc=%0d",
             a, w, s, got_done, got_err, rd_q.size(), wr_cnt, cyc_n);
  endtask

  // Compare the recorded line against the reference memory, then update it.
  task automatic check_line(input logic [AW-1:0] a, input logic w, input logic [3:0] s,
                            input logic [31:0] d0, input logic [31:0] d1,
                            input logic [31:0] d2, input logic [31:0] d3);
    logic [31:0] wd [4];
    logic [31:0] word;
    int ad;
    wd = '{d0, d1, d2, d3};
    check("done_seen", 32'(got_done), 32'd1);
    check("err_clear", 32'(got_err), 32'd0);
    check("bus_cycles", 32'(cyc_n), 32'(2 * BEATS));
    check("cyc_low_at_done", 32'(cyc_at_done), 32'd0);
    check("no_early_accept", 32'(early), 32'd0);
    if (w) begin
      check("wr_next_count", 32'(wr_cnt), 32'(BEATS));
      check("no_rd_on_write", 32'(rd_q.size()), 32'd0);
      for (int k = 0; k < BEATS; k++) begin
        ad = beat_addr(int'(a), k);
        word = ref_mem[ad];
        for (int b = 0; b < 4; b++)
          if (s[b]) word[8*b +: 8] = wd[k][8*b +: 8];
        ref_mem[ad] = word;
      end
    end else begin
      check("rd_valid_count", 32'(rd_q.size()), 32'(BEATS));
      check("no_wr_on_read", 32'(wr_cnt), 32'd0);
      check("rd_last_pos", 32'(last_pos), 32'(BEATS));
      check("done_after_last", 32'(done_after_last), 32'd1);
      for (int k = 0; k < BEATS && k < rd_q.size(); k++)
        check($sformatf("rd_beat%0d", k), rd_q[k], ref_mem[beat_addr(int'(a), k)]);
    end
  endtask

  initial begin
    logic [AW-1:0] a;
    logic          w;
    logic [3:0]    s;
    logic [31:0]   d [4];
    int            watch, bad;

    for (int i = 0; i < MSIZE; i++) ref_mem[i] = 32'(i);
    rst_i = 1'b1; mem_init = 1'b1; force_nak = 1'b0;
    req_valid = 1'b0; req_addr = '0; req_we = 1'b0; req_sel = '0; wr_data = '0;
    repeat (3) @(negedge clk_i);
    mem_init = 1'b0;
    rst_i = 1'b0;
    @(negedge clk_i);

    // Reset state
    check("rst_cyc", 32'(cyc_o), 32'd0);
    check("rst_stb", 32'(stb_o), 32'd0);
    check("rst_we", 32'(we_o), 32'd0);
    check("rst_adr", 32'(adr_o), 32'd0);
    check("rst_sel", 32'(sel_o), 32'd0);
    check("rst_outs", {26'd0, wr_next, rd_valid, rd_last, done, err, 1'b0}, 32'd0);
    check("rst_ready", 32'(req_ready), 32'd1);

    // Read line starting mid-line: order 0x12,0x13,0x10,0x11
    run_line(10'h012, 1'b0, 4'hF, 0, 0, 0, 0, 0);
    check_line(10'h012, 1'b0, 4'hF, 0, 0, 0, 0);

    // Full write line then readback
    run_line(10'h020, 1'b1, 4'hF, 32'hA0, 32'hA1, 32'hA2, 32'hA3, 0);
    check_line(10'h020, 1'b1, 4'hF, 32'hA0, 32'hA1, 32'hA2, 32'hA3);
    run_line(10'h020, 1'b0, 4'hF, 0, 0, 0, 0, 0);
    check_line(10'h020, 1'b0, 4'hF, 0, 0, 0, 0);

    // Partial write: low half-word lanes only
    run_line(10'h030, 1'b1, 4'b0011, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 0);
    check_line(10'h030, 1'b1, 4'b0011, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF);
    run_line(10'h030, 1'b0, 4'hF, 0, 0, 0, 0, 0);
    check_line(10'h030, 1'b0, 4'hF, 0, 0, 0, 0);
    if (rd_q.size() > 0) check("partial_word", rd_q[0], 32'h0000BEEF);
    else check("partial_word_present", 32'(rd_q.size()), 32'd4);

    // Back-to-back with req_valid held high
    run_line(10'h041, 1'b0, 4'hF, 0, 0, 0, 0, 1);
    check_line(10'h041, 1'b0, 4'hF, 0, 0, 0, 0);
    run_line(10'h047, 1'b0, 4'hF, 0, 0, 0, 0, 0);
    check_line(10'h047, 1'b0, 4'hF, 0, 0, 0, 0);

    // Reset during beat 2 of a read
    req_valid = 1'b1; req_addr = 10'h052; req_we = 1'b0; req_sel = 4'hF;
    watch = 0;
    while (!req_ready && watch < 50) begin @(negedge clk_i); watch++; end
    @(negedge clk_i);
    req_valid = 1'b0;
    while (!(cyc_o && adr_o == 10'h053) && watch < 100) begin @(negedge clk_i); watch++; end
    check("reach_beat2", 32'(adr_o), 32'h053);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    check("rst_mid_cyc", 32'(cyc_o), 32'd0);
    bad = 0;
    for (int t = 0; t < 8; t++) begin
      if (done || rd_valid || wr_next || cyc_o) bad++;
      @(negedge clk_i);
    end
    check("rst_mid_quiet", 32'(bad), 32'd0);
    $display("[TB] mid-line reset: quiet-cycle violations=%0d", bad);
    run_line(10'h052, 1'b0, 4'hF, 0, 0, 0, 0, 0);
    check_line(10'h052, 1'b0, 4'hF, 0, 0, 0, 0);

    // Randomised lines, each write followed by a wrapped readback
    for (int n = 0; n < 10; n++) begin
      a = AW'($urandom_range(0, MSIZE - 1));
      w = 1'($urandom_range(0, 1));
      s = w ? 4'($urandom_range(1, 15)) : 4'hF;
      for (int k = 0; k < 4; k++) d[k] = $urandom;
      run_line(a, w, s, d[0], d[1], d[2], d[3], 0);
      check_line(a, w, s, d[0], d[1], d[2], d[3]);
      if (w) begin
        a = {a[AW-1:2], 2'($urandom_range(0, 3))};
        run_line(a, 1'b0, 4'hF, 0, 0, 0, 0, 0);
        check_line(a, 1'b0, 4'hF, 0, 0, 0, 0);
      end
    end

`ifdef WB_TIMEOUT_EN
    // Slave never acks: line aborts with err after TIMEOUT cycles
    force_nak = 1'b1;
    run_line(10'h066, 1'b0, 4'hF, 0, 0, 0, 0, 0);
    force_nak = 1'b0;
    check("tmo_done", 32'(got_done), 32'd1);
    check("tmo_err", 32'(got_err), 32'd1);
    check("tmo_no_rd", 32'(rd_q.size()), 32'd0);
    check("tmo_latency", 32'(start_to_done >= 8 && start_to_done <= 9), 32'd1);
    run_line(10'h066, 1'b0, 4'hF, 0, 0, 0, 0, 0);
    check_line(10'h066, 1'b0, 4'hF, 0, 0, 0, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
